// File: rtl/mux_cfg_loader.sv
// Serial loader for 2:1 routing-mux selects: hunts a sync word, gathers N_MUX
// select bits plus even parity, and commits them to sel atomically.
module mux_cfg_loader #(
  parameter int          N_MUX = 2,
  parameter logic [7:0]  SYNC  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_bit,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic [N_MUX-1:0] sel,
  output logic             done,
  output logic             err,
  output logic [7:0]       frame_cnt
);

  localparam int IW = (N_MUX > 1) ? $clog2(N_MUX) : 1;

  // HUNT: sliding sync search | LOAD: select bits | PARITY: check | COMMIT: publish
  typedef enum logic [1:0] {HUNT, LOAD, PARITY, COMMIT} state_e;

  state_e           state_q, state_d;
  logic [7:0]       sr_q, sr_d;
  logic [N_MUX-1:0] stage_q, stage_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             par_q, par_d;
  logic [N_MUX-1:0] sel_q, sel_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;

  logic       accept;
  logic [7:0] sr_shift;

  assign cfg_ready = !rst && (state_q != COMMIT);
  assign accept    = cfg_valid && cfg_ready;
  assign sr_shift  = {sr_q[6:0], cfg_bit};

  assign sel       = sel_q;
  assign done      = done_q;
  assign err       = err_q;
  assign frame_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      sr_q    <= '0;
      stage_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      sel_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      stage_q <= stage_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    stage_d = stage_q;
    idx_d   = idx_q;
    par_d   = par_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    case (state_q)
      HUNT: begin
        if (accept) begin
          sr_d = sr_shift;
          // Shifter is cleared on lock so the next hunt never reuses old bits.
          if (sr_shift == SYNC) begin
            state_d = LOAD;
            sr_d    = '0;
            idx_d   = '0;
            par_d   = 1'b0;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          stage_d[idx_q] = cfg_bit;
          par_d          = par_q ^ cfg_bit;
          if (idx_q == IW'(N_MUX - 1)) begin
            state_d = PARITY;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      PARITY: begin
        if (accept) begin
          if (par_q ^ cfg_bit) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        sel_d   = stage_q;
        done_d  = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

endmodule

// File: tb/tb_mux_cfg_loader.sv
// Bench for mux_cfg_loader: directed frames plus randomized traffic, every cycle
// compared against a bit-stream-level reference model.
module tb_mux_cfg_loader;

  localparam int         N  = 2;
  localparam logic [7:0] SY = 8'hA5;

  logic         clk = 1'b0;
  logic         rst;
  logic         cfg_bit;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [N-1:0] sel;
  logic         done;
  logic         err;
  logic [7:0]   frame_cnt;

  always #5 clk = ~clk;

  mux_cfg_loader #(.N_MUX(N), .SYNC(SY)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_bit   (cfg_bit),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .sel       (sel),
    .done      (done),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  int total = 0;
  int bad   = 0;
  int edge_no = 0;
  bit rnd_stall = 0;

  // reference model: stream-level view of the framing rules
  logic [7:0]   m_win;
  bit           m_in;
  bit           m_q[$];
  bit           m_pend;
  logic [N-1:0] m_stage;
  logic [N-1:0] m_sel;
  logic [7:0]   m_cnt;
  bit           m_done;
  bit           m_err;
  bit           m_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_win  = '0;
    m_in   = 0;
    m_q.delete();
    m_pend = 0;
    m_stage = '0;
    m_sel  = '0;
    m_cnt  = '0;
  endtask

  task automatic model_bit(input bit b);
    int ones;
    if (!m_in) begin
      m_win = {m_win[6:0], b};
      if (m_win == SY) begin
        m_in  = 1;
        m_win = '0;
        m_q.delete();
      end
    end else begin
      m_q.push_back(b);
      if (m_q.size() == N + 1) begin
        ones = 0;
        foreach (m_q[k]) ones += int'(m_q[k]);
        if (ones % 2 == 0) begin
          m_pend = 1;
          for (int k = 0; k < N; k++) m_stage[k] = m_q[k];
        end else begin
          m_err = 1;
        end
        m_in = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("sel",       32'(sel),       32'(m_sel));
    chk("done",      32'(done),      32'(m_done));
    chk("err",       32'(err),       32'(m_err));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    chk("cfg_ready", 32'(cfg_ready), 32'(m_ready));
  endtask

  task automatic step(input bit v, input bit b, output bit acc);
    cfg_valid = v;
    cfg_bit   = b;
    acc = v && !rst && !m_pend;
    @(posedge clk);
    #1;
    edge_no++;
    m_done = 0;
    m_err  = 0;
    if (rst) begin
      model_reset();
    end else if (m_pend) begin
      m_sel  = m_stage;
      m_done = 1;
      m_cnt  = m_cnt + 8'd1;
      m_pend = 0;
    end else if (acc) begin
      model_bit(b);
    end
    m_ready = !rst && !m_pend;
    check_all();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 1'($urandom), acc);
  endtask

  task automatic send(input bit b);
    bit acc;
    int tries;
    tries = 0;
    if (rnd_stall && $urandom_range(0, 5) == 0) idle(int'($urandom_range(1, 3)));
    do begin
      step(1, b, acc);
      tries++;
    end while (!acc && tries < 4);
    chk("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send(v[i]);
  endtask

  task automatic send_frame(input logic [N-1:0] s, input bit badpar);
    send_byte(SY);
    for (int k = 0; k < N; k++) send(s[k]);
    send((^s) ^ badpar);
  endtask

  task automatic do_reset(input int n);
    bit acc;
    rst = 1;
    for (int i = 0; i < n; i++) step(1'($urandom), 1'($urandom), acc);
    rst = 0;
  endtask

  initial begin
    int e0;
    logic [7:0] sb;
    logic [N-1:0] rs;
    rst = 1;
    cfg_valid = 0;
    cfg_bit = 0;
    m_ready = 0;
    model_reset();

    // reset with random inputs, then ready must come up
    do_reset(3);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    idle(1);
    chk("ready_after_rst", 32'(cfg_ready), 32'd1);

    // good frame, continuous valid; sel lands 11 edges after first sync bit
    send(1'b1);
    e0 = edge_no;
    sb = SY;
    for (int i = 6; i >= 0; i--) send(sb[i]);
    send(1'b1); send(1'b0); send(1'b1);
    chk("ready_commit", 32'(cfg_ready), 32'd0);
    idle(1);
    chk("latency", 32'(edge_no - e0), 32'd11);
    chk("good_sel", 32'(sel), 32'd1);
    chk("good_cnt", 32'(frame_cnt), 32'd1);
    idle(2);

    // bad parity keeps sel/cnt; then a good frame commits
    send_byte(SY); send(1'b1); send(1'b1); send(1'b1);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_sel", 32'(sel), 32'd1);
    idle(1);
    send_frame(2'b11, 0);
    idle(1);
    chk("after_bad_sel", 32'(sel), 32'd3);
    chk("after_bad_cnt", 32'(frame_cnt), 32'd2);

    // noise before sync
    send(1); send(1); send(0); send(1); send(0);
    send_byte(SY); send(0); send(1); send(1);
    idle(1);
    chk("noise_sel", 32'(sel), 32'd2);

    // stalls inside sync, between config bits, before parity
    sb = SY;
    for (int i = 7; i >= 4; i--) send(sb[i]);
    idle(5);
    for (int i = 3; i >= 0; i--) send(sb[i]);
    send(1);
    idle(5);
    send(0);
    idle(5);
    send(1);
    idle(1);
    chk("stall_sel", 32'(sel), 32'd1);

    // commit 11, then reset after one config bit of the next frame
    send_frame(2'b11, 0);
    idle(1);
    chk("pre_rst_sel", 32'(sel), 32'd3);
    send_byte(SY); send(1);
    do_reset(1);
    chk("midrst_sel", 32'(sel), 32'd0);
    send_frame(2'b10, 0);
    idle(1);
    chk("post_rst_sel", 32'(sel), 32'd2);

    // randomized frames with noise, bad parity and stalls; 255 more commits wraps cnt
    rnd_stall = 1;
    for (int f = 0; f < 255; f++) begin
      if ($urandom_range(0, 7) == 0) begin
        rs = N'($urandom);
        send_frame(rs, 1);
      end
      rs = N'($urandom);
      send_frame(rs, 0);
    end
    rnd_stall = 0;
    idle(2);
    chk("wrap_cnt", 32'(frame_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_cfg_loader.md
# mux_cfg_loader

Serial configuration writer for runtime-selectable 2:1 routing muxes. It accepts a framed bit stream, hunts for a sync word and assembles `N_MUX` select bits. It checks even parity, then atomically commits the bits to `sel`, whose bit `k` drives the select of routing mux `k`. It is the producer side of the mux-select interface: `sel[k]=0` chooses input I0 and `sel[k]=1` chooses I1, with I0 as the power-on/reset default.

## Interface

Parameters:
- `N_MUX`, default 2. Number of routing muxes programmed; legal range 1..32.
- `SYNC`, default 8'hA5. Frame sync word, received MSB first.

Ports:
- `clk`  input  1  sole clock; all state changes on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `cfg_bit`  input  1  serial config data.
- `cfg_valid`  input  1  `cfg_bit` valid this cycle.
- `cfg_ready`  output  1  loader can accept a bit this cycle.
- `sel`  output  N_MUX  committed mux selects, registered.
- `done`  output  1  one-cycle pulse: `sel` was just updated.
- `err`  output  1  one-cycle pulse: frame rejected on parity.
- `frame_cnt`  output  8  count of committed frames, wraps 255→0.

## Operation

- A bit is accepted on a rising edge where `cfg_valid && cfg_ready` holds.
- Frame format: `SYNC` (8 bits, MSB first), then `N_MUX` config bits, then 1 parity bit.
  - The first config bit goes to `sel[0]`; config bit k goes to `sel[k]`.
  - The parity bit makes the total count of ones across the config bits and the parity bit even.
- States:
  - HUNT: `cfg_ready=1`.
    - Each accepted bit updates the 8-bit sync shifter with `sr <= {sr[6:0],cfg_bit}`.
    - If `{sr[6:0],cfg_bit}==SYNC`, go to LOAD and clear `sr` to 0 and the bit index to 0.
    - Overlapping or partial sync patterns are found by the sliding compare; there is no bit-slip logic.
  - LOAD: `cfg_ready=1`.
    - Each accepted bit is written to `stage[idx]` and the running parity is XORed.
    - When the bit at `idx==N_MUX-1` is accepted, go to PARITY.
  - PARITY: `cfg_ready=1`.
    - On the accepted bit, if `parity_acc ^ cfg_bit == 0`, go to COMMIT.
    - Otherwise set `err<=1` for one cycle and go to HUNT; `sel` is unchanged.
  - COMMIT: `cfg_ready=0` for exactly one cycle.
    - At its closing edge: `sel<=stage`, `done<=1`, `frame_cnt<=frame_cnt+1` (mod 256), state goes to HUNT.
- `cfg_valid` low in any state is a stall: state, index and parity hold, and no timeout exists.
- `sel` never shows a partially loaded frame; `stage` is internal only.
- The bits following a frame are hunted fresh. The `SYNC` shifter is cleared on the HUNT→LOAD transition, so sync detection never uses bits from before that transition.
- `done` and `err` are never high in the same cycle.

## Timing

- Reset values:
  - `sel=0` (all muxes select I0), `cfg_ready=0` during the reset cycle, `done=0`, `err=0`, `frame_cnt=0`.
  - State is HUNT, and `sr`, `stage`, index and parity accumulator are all 0.
- `cfg_ready` goes to 1 on the first cycle after `rst` deasserts.
- Reset mid-frame discards all partial state; `sel` returns to 0 even if previously committed.
- Latency with `cfg_valid` held high and the first sync bit accepted at edge E:
  - Last sync bit is accepted at E+7.
  - Config bits are accepted at E+8 .. E+7+N_MUX.
  - Parity is accepted at E+8+N_MUX.
  - COMMIT is the following cycle.
  - `sel` and `done` are visible after edge E+9+N_MUX.
- `err` is visible in the cycle after the parity edge; HUNT is active in that same cycle.
- The minimum gap between committed frames is one cycle, the COMMIT cycle with `cfg_ready=0`.
- `done` and `err` are registered and last exactly one cycle.

## Test plan

- Reset: hold `rst` 3 cycles with random `cfg_*`. Required: `sel=2'b00`, `done=0`, `err=0`, `frame_cnt=0`, and `cfg_ready=1` one cycle after release.
- Good frame, N_MUX=2, continuous valid: stream 10100101,1,0,1. Required:
  - `cfg_ready=0` for one cycle after the parity bit.
  - Then `sel=2'b01` with `done` pulsing once.
  - `frame_cnt=1`.
  - `sel` updates exactly 11 edges after the first sync bit.
- Bad parity: stream 10100101,1,1,1. Required: `err` pulses once, `sel` keeps its prior value, `frame_cnt` unchanged, and HUNT resumes (a following valid frame commits normally).
- Sync hunt with noise: stream 1,1,0,1,0 then 10100101,0,1,1. Required: no `done` or `err` before the real frame, then `sel=2'b10` and `done`.
- Stalls: drop `cfg_valid` for 5 cycles inside the sync word, between config bits, and before parity. Required: same `sel` result as the unstalled case, and `sel`/`done` unchanged during the stalls.
- Reset mid-frame, then wrap: commit `sel=2'b11`, then assert `rst` after 1 config bit of a new frame. Required: `sel=0` and the next full frame commits cleanly. Then commit 256 good frames: `frame_cnt` returns to 0.
